// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU bus to on-chip RAM bridge.
package bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT     = 3'd1,
      ST_RD_DRIVE = 3'd2,
      ST_WR_HOLD  = 3'd3,
      ST_ERR_HOLD = 3'd4
   } state_t;

   typedef enum logic {
      KIND_READ  = 1'b0,
      KIND_WRITE = 1'b1
   } kind_t;

   // S1S0 cycle-type codes
   localparam logic [1:0] CYC_FETCH  = 2'b11;
   localparam logic [1:0] CYC_MREAD  = 2'b10;
   localparam logic [1:0] CYC_MWRITE = 2'b01;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bus_ram.sv
// Byte-wide single-port-style RAM: synchronous write, registered read.
// The storage array is never reset; only the read register clears so the
// bus bridge has a defined read value after reset.
module bus_ram #(
   parameter int ADDR_W = 10
) (
   input  logic              clock,
   input  logic              reset_in,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   logic [7:0] mem [2**ADDR_W];

   // synchronous write into the array
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   // registered read, loaded only when the controller asks for it
   always_ff @(posedge clock or negedge reset_in) begin
      if (!reset_in)  rdata <= 8'h00;
      else if (re)    rdata <= mem[raddr];
   end

endmodule

// File: rtl/bus_mem_ctrl.sv
// CPU bus slave mapping a 2**ADDR_W byte RAM into the memory space, with
// programmable wait states, tri-state data return and strobe error trap.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | waiting for a selected RDn/WRn falling edge
// ST_WAIT     | counting wait states, READY held low
// ST_RD_DRIVE | read data registered, DATA driven while RDn low
// ST_WR_HOLD  | capturing DATA while WRn low, commit on WRn rise
// ST_ERR_HOLD | both strobes seen low; wait until both are high again
module bus_mem_ctrl
   import bus_pkg::*;
#(
   parameter int          ADDR_W     = 10,
   parameter logic [15:0] BASE       = 16'h0000,
   parameter int          MEM_WAIT   = 2,
   parameter int          FETCH_WAIT = 1
) (
   input  logic        clock,
   input  logic        reset_in,
   input  logic [15:0] ADD,
   inout  wire  [7:0]  DATA,
   input  logic        RDn,
   input  logic        WRn,
   input  logic        IO_Mn,
   input  logic        S1,
   input  logic        S0,
   output logic        READY,
   output logic        BUS_ERR
);

   localparam int WMAX   = max_int(MEM_WAIT, FETCH_WAIT);
   localparam int WCNT_W = (WMAX < 1) ? 1 : $clog2(WMAX + 1);
   localparam logic [WCNT_W-1:0] FETCH_CNT = WCNT_W'(FETCH_WAIT);
   localparam logic [WCNT_W-1:0] MEM_CNT   = WCNT_W'(MEM_WAIT);
   localparam logic [WCNT_W-1:0] ONE_CNT   = WCNT_W'(1);

   state_t              state;
   kind_t               kind;
   logic [ADDR_W-1:0]   addr_q;
   logic [WCNT_W-1:0]   wcnt;
   logic [7:0]          wdata;
   logic [7:0]          rdata;
   logic                rd_q;
   logic                wr_q;

   logic                sel;
   logic                both_low;
   logic                start_rd;
   logic                start_wr;
   logic [WCNT_W-1:0]   load_cnt;
   logic                ram_re;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_raddr;

   // strobe edge detection, window decode and RAM port control
   always_comb begin
      sel       = !IO_Mn && (ADD[15:ADDR_W] == BASE[15:ADDR_W]);
      both_low  = !RDn && !WRn;
      start_rd  = (state == ST_IDLE) && !both_low && rd_q && !RDn && sel;
      start_wr  = (state == ST_IDLE) && !both_low && wr_q && !WRn && sel;
      load_cnt  = ({S1, S0} == CYC_FETCH) ? FETCH_CNT : MEM_CNT;
      // zero-wait reads enter RD_DRIVE straight from IDLE, before addr_q holds the address
      ram_raddr = (state == ST_IDLE) ? ADD[ADDR_W-1:0] : addr_q;
      ram_re    = (start_rd && (load_cnt == '0)) ||
                  ((state == ST_WAIT) && (kind == KIND_READ) && (wcnt <= ONE_CNT) && !both_low);
      ram_we    = (state == ST_WR_HOLD) && WRn;
   end

   assign DATA = ((state == ST_RD_DRIVE) && !RDn) ? rdata : 8'hzz;

   // bus protocol FSM with registered READY / BUS_ERR
   always_ff @(posedge clock or negedge reset_in) begin
      if (!reset_in) begin
         state   <= ST_IDLE;
         kind    <= KIND_READ;
         addr_q  <= '0;
         wcnt    <= '0;
         wdata   <= 8'h00;
         READY   <= 1'b1;
         BUS_ERR <= 1'b0;
         rd_q    <= 1'b1;
         wr_q    <= 1'b1;
      end else begin
         rd_q <= RDn;
         wr_q <= WRn;
         if (both_low) begin
            state   <= ST_ERR_HOLD;
            BUS_ERR <= 1'b1;
            READY   <= 1'b1;
            wcnt    <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_rd || start_wr) begin
                     addr_q <= ADD[ADDR_W-1:0];
                     kind   <= start_wr ? KIND_WRITE : KIND_READ;
                     wcnt   <= load_cnt;
                     if (load_cnt != '0) begin
                        state <= ST_WAIT;
                        READY <= 1'b0;
                     end else begin
                        state <= start_wr ? ST_WR_HOLD : ST_RD_DRIVE;
                        READY <= 1'b1;
                     end
                  end
               end
               ST_WAIT: begin
                  if (wcnt <= ONE_CNT) begin
                     wcnt  <= '0;
                     READY <= 1'b1;
                     state <= (kind == KIND_WRITE) ? ST_WR_HOLD : ST_RD_DRIVE;
                  end else begin
                     wcnt <= wcnt - ONE_CNT;
                  end
               end
               ST_RD_DRIVE: begin
                  if (RDn) state <= ST_IDLE;
               end
               ST_WR_HOLD: begin
                  if (!WRn) wdata <= DATA;
                  else      state <= ST_IDLE;
               end
               ST_ERR_HOLD: begin
                  READY <= 1'b1;
                  if (RDn && WRn) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   bus_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clock    (clock),
      .reset_in (reset_in),
      .we       (ram_we),
      .waddr    (addr_q),
      .wdata    (wdata),
      .re       (ram_re),
      .raddr    (ram_raddr),
      .rdata    (rdata)
   );

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Scoreboard bench for bus_mem_ctrl: stimulus pushes expectations, a
// negedge monitor compares read returns and status samples.
module tb_bus_mem_ctrl;

   typedef struct {
      string      name;
      logic [7:0] data;
      int         waits;
   } rd_exp_t;

   typedef struct {
      string      name;
      int         sel;   // 0 READY, 1 BUS_ERR, 2 DATA, 3 wait bound expired
      logic [7:0] exp;
   } st_exp_t;

   logic        clock = 1'b0;
   logic        reset_in = 1'b0;
   logic [15:0] ADD = 16'h0000;
   wire  [7:0]  DATA;
   logic        RDn = 1'b1;
   logic        WRn = 1'b1;
   logic        IO_Mn = 1'b1;
   logic        S1 = 1'b0;
   logic        S0 = 1'b0;
   logic        READY;
   logic        BUS_ERR;
   logic [7:0]  tb_data = 8'h00;
   logic        tb_drive = 1'b0;

   int n_vec = 0;
   int n_fail = 0;

   rd_exp_t rd_q[$];
   st_exp_t st_q[$];

   assign DATA = tb_drive ? tb_data : 8'hzz;

   // released bus floats to 0xFF so hi-z is observable
   for (genvar i = 0; i < 8; i++) begin : g_pu
      pullup (DATA[i]);
   end

   always #5 clock = ~clock;

   bus_mem_ctrl #(
      .ADDR_W     (10),
      .BASE       (16'h0000),
      .MEM_WAIT   (2),
      .FETCH_WAIT (1)
   ) dut (
      .clock    (clock),
      .reset_in (reset_in),
      .ADD      (ADD),
      .DATA     (DATA),
      .RDn      (RDn),
      .WRn      (WRn),
      .IO_Mn    (IO_Mn),
      .S1       (S1),
      .S0       (S0),
      .READY    (READY),
      .BUS_ERR  (BUS_ERR)
   );

   // monitor: status samples and read-cycle returns
   int         lowcnt = 0;
   logic [7:0] cap = 8'hFF;
   logic       prev_rdn = 1'b1;
   logic [7:0] act;
   st_exp_t    s;
   rd_exp_t    r;

   initial begin
      forever begin
         @(negedge clock);
         while (st_q.size() > 0) begin
            s = st_q.pop_front();
            n_vec++;
            case (s.sel)
               0:       act = {7'b0, READY};
               1:       act = {7'b0, BUS_ERR};
               2:       act = DATA;
               default: act = 8'h00;
            endcase
            if (s.sel == 3) begin
               n_fail++;
               $display("FAIL %s: wait bound expired, READY never returned high", s.name);
            end else if (act !== s.exp) begin
               n_fail++;
               $display("FAIL %s: got %02h expected %02h", s.name, act, s.exp);
            end
         end
         if (!RDn) begin
            if (!READY) lowcnt++;
            cap = DATA;
         end else if (!prev_rdn) begin
            if (rd_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_read: got data %02h with no expectation queued", cap);
            end else begin
               r = rd_q.pop_front();
               n_vec++;
               if (lowcnt != r.waits) begin
                  n_fail++;
                  $display("FAIL %s_waits: got %0d expected %0d", r.name, lowcnt, r.waits);
               end
               n_vec++;
               if (cap !== r.data) begin
                  n_fail++;
                  $display("FAIL %s_data: got %02h expected %02h", r.name, cap, r.data);
               end
               n_vec++;
               if (DATA !== 8'hFF) begin
                  n_fail++;
                  $display("FAIL %s_release: got %02h expected ff (hi-z)", r.name, DATA);
               end
            end
            lowcnt = 0;
         end
         prev_rdn = RDn;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input int sel, input logic [7:0] exp);
      st_q.push_back('{name, sel, exp});
   endtask

   task automatic wait_ready(input string name);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (READY) return;
      end
      chk(name, 3, 8'h00);
   endtask

   task automatic do_read(input string name, input logic [15:0] a, input logic [1:0] cyc,
                          input logic iom, input logic [7:0] exp, input int waits);
      rd_q.push_back('{name, exp, waits});
      tick();
      ADD = a; {S1, S0} = cyc; IO_Mn = iom; RDn = 1'b0;
      @(posedge clock);
      wait_ready(name);
      @(posedge clock);
      #1 RDn = 1'b1; IO_Mn = 1'b1;
      tick();
      tick();
   endtask

   task automatic do_write(input string name, input logic [15:0] a, input logic iom,
                           input logic [7:0] d);
      tick();
      ADD = a; {S1, S0} = 2'b01; IO_Mn = iom; tb_data = d; tb_drive = 1'b1; WRn = 1'b0;
      @(posedge clock);
      wait_ready(name);
      @(posedge clock);
      #1 WRn = 1'b1;
      @(posedge clock);
      #1 tb_drive = 1'b0; IO_Mn = 1'b1;
      tick();
   endtask

   initial begin
      chk("rst_ready", 0, 8'h01);
      chk("rst_bus_err", 1, 8'h00);
      chk("rst_data_hiz", 2, 8'hFF);
      repeat (3) tick();
      reset_in = 1'b1;
      tick();

      do_write("w005", 16'h0005, 1'b0, 8'hA5);
      do_read("r005", 16'h0005, 2'b10, 1'b0, 8'hA5, 2);

      do_write("w100", 16'h0100, 1'b0, 8'hC3);
      do_read("fetch100", 16'h0100, 2'b11, 1'b0, 8'hC3, 1);

      do_write("w010", 16'h0010, 1'b0, 8'h3C);
      do_write("w011", 16'h0011, 1'b0, 8'h77);
      chk("after_write_hiz", 2, 8'hFF);
      do_read("r010", 16'h0010, 2'b10, 1'b0, 8'h3C, 2);
      do_read("r011", 16'h0011, 2'b10, 1'b0, 8'h77, 2);

      do_read("rd_io", 16'h0005, 2'b10, 1'b1, 8'hFF, 0);
      do_read("rd_miss", 16'h8000, 2'b10, 1'b0, 8'hFF, 0);
      do_write("wr_miss", 16'h8005, 1'b0, 8'h11);
      do_read("r005_again", 16'h0005, 2'b10, 1'b0, 8'hA5, 2);

      // both strobes fall together from IDLE
      do_write("w040", 16'h0040, 1'b0, 8'h22);
      chk("bus_err_clear", 1, 8'h00);
      rd_q.push_back('{"err_both", 8'hFF, 0});
      tick();
      ADD = 16'h0040; {S1, S0} = 2'b01; IO_Mn = 1'b0; tb_data = 8'h66; tb_drive = 1'b1;
      RDn = 1'b0; WRn = 1'b0;
      @(posedge clock);
      #1 tb_drive = 1'b0;
      chk("err_both_flag", 1, 8'h01);
      chk("err_both_ready", 0, 8'h01);
      chk("err_both_hiz", 2, 8'hFF);
      tick();
      RDn = 1'b1; WRn = 1'b1; IO_Mn = 1'b1;
      tick();
      tick();
      do_read("r040", 16'h0040, 2'b10, 1'b0, 8'h22, 2);

      // RDn falls during WR_HOLD: pending write must be dropped
      do_write("w030", 16'h0030, 1'b0, 8'h11);
      rd_q.push_back('{"err_hold", 8'hFF, 0});
      tick();
      ADD = 16'h0030; {S1, S0} = 2'b01; IO_Mn = 1'b0; tb_data = 8'h99; tb_drive = 1'b1;
      WRn = 1'b0;
      @(posedge clock);
      wait_ready("w030_cancel");
      @(posedge clock);
      #1 RDn = 1'b0;
      @(posedge clock);
      #1 tb_drive = 1'b0;
      chk("err_hold_flag", 1, 8'h01);
      chk("err_hold_ready", 0, 8'h01);
      chk("err_hold_hiz", 2, 8'hFF);
      tick();
      WRn = 1'b1;
      tick();
      RDn = 1'b1; IO_Mn = 1'b1;
      tick();
      tick();
      do_read("r030", 16'h0030, 2'b10, 1'b0, 8'h11, 2);
      chk("bus_err_sticky", 1, 8'h01);

      // reset during the wait of a write
      do_write("w020", 16'h0020, 1'b0, 8'h42);
      tick();
      ADD = 16'h0020; {S1, S0} = 2'b01; IO_Mn = 1'b0; tb_data = 8'h5A; tb_drive = 1'b1;
      WRn = 1'b0;
      @(posedge clock);
      #1 chk("wait_ready_low", 0, 8'h00);
      @(posedge clock);
      #1 reset_in = 1'b0;
      chk("midrst_ready", 0, 8'h01);
      chk("midrst_bus_err", 1, 8'h00);
      tick();
      WRn = 1'b1; tb_drive = 1'b0; IO_Mn = 1'b1;
      tick();
      reset_in = 1'b1;
      tick();
      do_read("r020", 16'h0020, 2'b10, 1'b0, 8'h42, 2);
      do_read("r010_final", 16'h0010, 2'b10, 1'b0, 8'h3C, 2);

      for (int i = 0; i < 50 && (st_q.size() != 0 || rd_q.size() != 0); i++) @(negedge clock);
      @(posedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
